// File: rtl/loa_error_monitor.sv
// loa_error_monitor: on-chip error-metric engine for a Lower-part-OR Adder.
//
// Two Galois LFSRs feed operand pairs into an N-bit LOA (approximate lower
// K bits) and an exact adder. Over a programmed number of samples the block
// accumulates the error count, the summed error distance and the maximum
// error distance. Software derives ER, MED and NMED from these totals.
//
// Pipeline: stage 1 registers X/Y, stage 2 registers S, E and |S-E|,
// stage 3 updates the accumulators. Results update live and are final
// when done pulses.
//
// Optional build macro: LOA_MON_SIGNED_ERR_EN adds the sum_sed output,
// the signed sum of (S - E), to expose error bias.

`timescale 1ns / 1ps

module loa_error_monitor #(
  parameter int N  = 16,  // operand/sum width (4..32)
  parameter int K  = 8,   // approximate lower-part width (0..N-1)
  parameter int CW = 32   // sample/error counter width
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [CW-1:0]   num_samples,
  input  logic [31:0]     seed,
  output logic            busy,
  output logic            done,
  output logic [CW-1:0]   samples_done,
  output logic [CW-1:0]   err_count,
  output logic [N+CW-1:0] sum_ed,
  output logic [N-1:0]    max_ed
`ifdef LOA_MON_SIGNED_ERR_EN
  ,
  output logic signed [N+CW:0] sum_sed
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [31:0] LFSR_MASK  = 32'h8020_0003;  // x^32+x^22+x^2+x+1
  localparam logic [31:0] SEED_B_XOR = 32'hA5A5_5A5A;

  // Bits [K-1:0] form the OR-ed lower part; zero mask when K == 0.
  localparam logic [N-1:0] LO_MASK = N'((64'd1 << K) - 64'd1);
  // Position of bit K-1 (source of the carry into the upper part).
  localparam int           KM1     = (K > 0) ? K - 1 : 0;
  localparam logic [N-1:0] CIN_BIT = (K > 0) ? N'(64'd1 << KM1) : '0;
  // Weight of the injected carry, i.e. bit K of the sum.
  localparam logic [N-1:0] CIN_ADD = N'(64'd1 << K);

  // One step of the right-shifting Galois LFSR.
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
  endfunction

  // The all-zero state is a lock-up state; substitute 1.
  function automatic logic [31:0] nonzero(input logic [31:0] v);
    return (v == 32'h0) ? 32'h1 : v;
  endfunction

  // ---------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------
  state_t        state, next_state;
  logic          busy_d, done_d;
  logic          load;       // accepted start: latch config, clear results
  logic          issue;      // present one operand pair this cycle
  logic          flush;      // abort: drop in-flight samples
  logic [CW-1:0] num_q;
  logic [CW-1:0] issue_cnt;
  logic          drain_cnt;
  logic          last_issue;

  assign last_issue = (issue_cnt == num_q - CW'(1));

  // Next-state and control decode for the run sequencer.
  // NOTE: every signal gets a default before the case so that no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    busy_d     = busy;
    done_d     = 1'b0;
    load       = 1'b0;
    issue      = 1'b0;
    flush      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          load       = 1'b1;
          busy_d     = 1'b1;
          next_state = (num_samples == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          flush      = 1'b1;
          busy_d     = 1'b0;
          next_state = S_IDLE;
        end else begin
          issue = 1'b1;
          if (last_issue) next_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          flush      = 1'b1;
          busy_d     = 1'b0;
          next_state = S_IDLE;
        end else if (drain_cnt) begin
          next_state = S_DONE;
        end
      end
      S_DONE: begin
        done_d     = 1'b1;
        busy_d     = 1'b0;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // State register.
  // NOTE: sequential blocks use non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Registered status outputs, latched run length and issue/drain counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      num_q     <= '0;
      issue_cnt <= '0;
      drain_cnt <= 1'b0;
    end else begin
      busy      <= busy_d;
      done      <= done_d;
      drain_cnt <= (state == S_DRAIN && !abort) ? ~drain_cnt : 1'b0;
      if (load) begin
        num_q     <= num_samples;
        issue_cnt <= '0;
      end else if (issue) begin
        issue_cnt <= issue_cnt + CW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus generator
  // ---------------------------------------------------------------------
  logic [31:0] lfsr_a, lfsr_b;

  // Seed on start; step after each issue so the first sample is unstepped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_a <= 32'h1;
      lfsr_b <= 32'h1;
    end else if (load) begin
      lfsr_a <= nonzero(seed);
      lfsr_b <= nonzero(seed ^ SEED_B_XOR);
    end else if (issue) begin
      lfsr_a <= lfsr_step(lfsr_a);
      lfsr_b <= lfsr_step(lfsr_b);
    end
  end

  // ---------------------------------------------------------------------
  // Stage 1: operand registers
  // ---------------------------------------------------------------------
  logic         s1_valid;
  logic [N-1:0] s1_x, s1_y;

  // Capture the current LFSR taps as the operand pair.
  // NOTE: the datapath registers are reset as well; the cost is small and
  // it keeps every observable value deterministic after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
    end else begin
      s1_valid <= issue;
      if (issue) begin
        s1_x <= lfsr_a[N-1:0];
        s1_y <= lfsr_b[N-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------
  // LOA, exact adder and error distance (combinational, between s1 and s2)
  // ---------------------------------------------------------------------
  logic         cin;
  logic [N-1:0] upper_sum;
  logic [N-1:0] loa_s;
  logic [N-1:0] exact_e;
  logic [N-1:0] ed;

  // Lower bits are OR-ed; the upper part adds with a carry taken from the
  // AND of the top lower-part bits. Carry-out of both adders is dropped.
  always_comb begin
    cin       = |(s1_x & s1_y & CIN_BIT);
    upper_sum = (s1_x & ~LO_MASK) + (s1_y & ~LO_MASK) + (cin ? CIN_ADD : '0);
    loa_s     = ((s1_x | s1_y) & LO_MASK) | (upper_sum & ~LO_MASK);
    exact_e   = s1_x + s1_y;
    ed        = (loa_s >= exact_e) ? (loa_s - exact_e) : (exact_e - loa_s);
  end

  // ---------------------------------------------------------------------
  // Stage 2: result registers
  // ---------------------------------------------------------------------
  logic         s2_valid;
  logic [N-1:0] s2_s, s2_e, s2_ed;

  // Register S, E and ED; an abort kills the sample moving into stage 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_s     <= '0;
      s2_e     <= '0;
      s2_ed    <= '0;
    end else begin
      s2_valid <= s1_valid && !flush;
      if (s1_valid) begin
        s2_s  <= loa_s;
        s2_e  <= exact_e;
        s2_ed <= ed;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 3: accumulators
  // ---------------------------------------------------------------------
  logic acc_en;

  assign acc_en = s2_valid && !flush;

  // Clear on accepted start, accumulate valid samples, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samples_done <= '0;
      err_count    <= '0;
      sum_ed       <= '0;
      max_ed       <= '0;
    end else if (load) begin
      samples_done <= '0;
      err_count    <= '0;
      sum_ed       <= '0;
      max_ed       <= '0;
    end else if (acc_en) begin
      samples_done <= samples_done + CW'(1);
      err_count    <= err_count + CW'(s2_s != s2_e);
      sum_ed       <= sum_ed + {{CW{1'b0}}, s2_ed};
      if (s2_ed > max_ed) max_ed <= s2_ed;
    end
  end

`ifdef LOA_MON_SIGNED_ERR_EN
  logic [N:0] s2_sed;

  // Signed error S - E as an (N+1)-bit two's-complement value.
  assign s2_sed = {1'b0, s2_s} - {1'b0, s2_e};

  // Signed error accumulator; same clear/hold rules as sum_ed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_sed <= '0;
    end else if (load) begin
      sum_sed <= '0;
    end else if (acc_en) begin
      sum_sed <= sum_sed + $signed({{CW{s2_sed[N]}}, s2_sed});
    end
  end
`endif

endmodule
